// File: rtl/flag_reg.sv
// flag_reg: ZNCV flag register with masked update, save/restore stack and condition evaluation
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sta_in[3:0]           ZNCV from status generator (Z,N,C,V = bit3..0)
//   op_en[1:0]            ALU mode of committed result (0x: Z,N only; 1x: all)
//   upd                   commit strobe
//   push, pop             save / restore flags (both together = stack no-op)
//   clr_err               clear sticky stack error
//   cond[3:0]             condition code select
//   flags[3:0]            registered ZNCV
//   cond_true             cond evaluated against flags (combinational)
//   stk_level[3:0]        valid stack entries
//   stk_full, stk_empty   level == STACK_DEPTH / level == 0
//   stk_err               sticky overflow/underflow
module flag_reg #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sta_in,
    input  logic [1:0] op_en,
    input  logic       upd,
    input  logic       push,
    input  logic       pop,
    input  logic       clr_err,
    input  logic [3:0] cond,
    output logic [3:0] flags,
    output logic       cond_true,
    output logic [3:0] stk_level,
    output logic       stk_full,
    output logic       stk_empty,
    output logic       stk_err
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);
    logic [3:0] stack [STACK_DEPTH];
    logic       do_push, do_pop, push_ok, pop_ok, err_set;
    logic [3:0] upd_val, lvl_dec;
    logic [7:0] base;
    always_comb begin
        do_push   = push & ~pop;
        do_pop    = pop & ~push;
        stk_full  = stk_level == DEPTH;
        stk_empty = stk_level == 4'd0;
        push_ok   = do_push & ~stk_full;
        pop_ok    = do_pop & ~stk_empty;
        err_set   = (do_push & stk_full) | (do_pop & stk_empty);
        lvl_dec   = stk_level - 4'd1;
        upd_val   = op_en[1] ? sta_in : {sta_in[3:2], flags[1:0]};
        // Odd codes are the complement of the preceding even code, so only
        // eight base terms are needed; AL/NV fall out as 1 and ~1.
        base = {1'b1,
                ~flags[3] & (flags[2] == flags[0]),
                flags[2] == flags[0],
                flags[1] & ~flags[3],
                flags[0], flags[2], flags[1], flags[3]};
        cond_true = base[cond[3:1]] ^ cond[0];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags     <= 4'd0;
            stk_level <= 4'd0;
            stk_err   <= 1'b0;
        end else begin
            flags     <= pop_ok ? stack[lvl_dec[AW-1:0]] : upd ? upd_val : flags;
            stk_level <= push_ok ? stk_level + 4'd1 : pop_ok ? lvl_dec : stk_level;
            stk_err   <= err_set | (stk_err & ~clr_err);
        end
    end
    // Storage is not reset; entries at or above stk_level are don't-care.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) stack[stk_level[AW-1:0]] <= flags;
    end
endmodule

// File: tb/tb_flag_reg.sv
// tb_flag_reg: directed scoreboard bench for flag_reg
module tb_flag_reg;
    logic       clk = 1'b0;
    logic       rst_n, upd, push, pop, clr_err;
    logic [3:0] sta_in, cond;
    logic [1:0] op_en;
    logic [3:0] flags, stk_level;
    logic       cond_true, stk_full, stk_empty, stk_err;
    int         n_vec = 0;
    int         n_bad = 0;

    typedef struct {
        string      tag;
        logic [3:0] f;
        logic [3:0] l;
        logic       e;
    } exp_t;
    exp_t exp_q[$];

    flag_reg #(.STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .sta_in(sta_in), .op_en(op_en), .upd(upd),
        .push(push), .pop(pop), .clr_err(clr_err), .cond(cond), .flags(flags),
        .cond_true(cond_true), .stk_level(stk_level), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
        logic z, n, c, v;
        {z, n, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of stimulus, queue the expected state, compare after the edge.
    task automatic step(input string tag, input logic rn, input logic u, input logic [1:0] op,
                        input logic [3:0] sta, input logic ps, input logic pp, input logic ce,
                        input logic [3:0] ef, input logic [3:0] el, input logic ee);
        exp_t e;
        logic [7:0] obs, req;
        rst_n = rn; upd = u; op_en = op; sta_in = sta; push = ps; pop = pp; clr_err = ce;
        exp_q.push_back('{tag, ef, el, ee});
        @(posedge clk);
        #1;
        rst_n = 1'b1; upd = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        e = exp_q.pop_front();
        obs = {flags, stk_level[2:0], stk_err};
        req = {e.f, e.l[2:0], e.e};
        n_vec++;
        assert (obs === req && stk_level === e.l) else begin
            n_bad++;
            $error("FAIL %s: flags/lvl/err got %b/%0d/%b want %b/%0d/%b",
                   e.tag, flags, stk_level, stk_err, e.f, e.l, e.e);
        end
        n_vec++;
        assert (stk_full === (e.l == 4'd4) && stk_empty === (e.l == 4'd0)) else begin
            n_bad++;
            $error("FAIL %s_fe: full/empty got %b/%b want %b/%b",
                   e.tag, stk_full, stk_empty, e.l == 4'd4, e.l == 4'd0);
        end
    endtask

    task automatic chk_cond(input string tag, input logic [3:0] cc, input logic exp_ct);
        cond = cc;
        #1;
        n_vec++;
        assert (cond_true === exp_ct) else begin
            n_bad++;
            $error("FAIL %s cond=%h: cond_true got %b want %b", tag, cc, cond_true, exp_ct);
        end
    endtask

    initial begin
        rst_n = 1'b0; upd = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        sta_in = 4'd0; op_en = 2'd0; cond = 4'd0;
        step("reset", 0, 0, 2'b00, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 16; i++) chk_cond("rst_cond", 4'(i), cond_ref(4'(i), 4'b0000));
        step("upd_add", 1, 1, 2'b10, 4'b0110, 0, 0, 0, 4'b0110, 0, 0);
        chk_cond("cs", 4'h2, 1'b1);
        chk_cond("ge", 4'hA, 1'b0);
        step("set_0011", 1, 1, 2'b10, 4'b0011, 0, 0, 0, 4'b0011, 0, 0);
        step("logic_mask", 1, 1, 2'b00, 4'b1100, 0, 0, 0, 4'b1111, 0, 0);
        step("shift_mask", 1, 1, 2'b01, 4'b0000, 0, 0, 0, 4'b0011, 0, 0);
        for (int i = 0; i < 16; i++) chk_cond("c0011", 4'(i), cond_ref(4'(i), 4'b0011));
        step("mul_all", 1, 1, 2'b11, 4'b1000, 0, 0, 0, 4'b1000, 0, 0);
        step("push1", 1, 1, 2'b10, 4'b0100, 1, 0, 0, 4'b0100, 1, 0);
        step("push2", 1, 1, 2'b10, 4'b0010, 1, 0, 0, 4'b0010, 2, 0);
        step("push3", 1, 1, 2'b10, 4'b0001, 1, 0, 0, 4'b0001, 3, 0);
        step("push4", 1, 0, 2'b00, 4'b0000, 1, 0, 0, 4'b0001, 4, 0);
        step("ovf", 1, 0, 2'b00, 4'b0000, 1, 0, 0, 4'b0001, 4, 1);
        step("pop1", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b0001, 3, 1);
        step("pop2", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b0010, 2, 1);
        step("pop3", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b0100, 1, 1);
        step("pop4", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b1000, 0, 1);
        step("clr1", 1, 0, 2'b00, 4'b0000, 0, 0, 1, 4'b1000, 0, 0);
        step("udf_upd", 1, 1, 2'b11, 4'b1010, 0, 1, 0, 4'b1010, 0, 1);
        step("clr2", 1, 0, 2'b00, 4'b0000, 0, 0, 1, 4'b1010, 0, 0);
        step("set_wins", 1, 0, 2'b00, 4'b0000, 0, 1, 1, 4'b1010, 0, 1);
        step("clr3", 1, 0, 2'b00, 4'b0000, 0, 0, 1, 4'b1010, 0, 0);
        step("pushA", 1, 0, 2'b00, 4'b0000, 1, 0, 0, 4'b1010, 1, 0);
        step("set_0101", 1, 1, 2'b10, 4'b0101, 0, 0, 0, 4'b0101, 1, 0);
        step("pushB", 1, 0, 2'b00, 4'b0000, 1, 0, 0, 4'b0101, 2, 0);
        step("set_0000", 1, 1, 2'b10, 4'b0000, 0, 0, 0, 4'b0000, 2, 0);
        step("pop_over_upd", 1, 1, 2'b10, 4'b1111, 0, 1, 0, 4'b0101, 1, 0);
        step("pushC", 1, 0, 2'b00, 4'b0000, 1, 0, 0, 4'b0101, 2, 0);
        step("push_pop", 1, 1, 2'b00, 4'b1000, 1, 1, 0, 4'b1001, 2, 0);
        step("pop_after_pp", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b0101, 1, 0);
        step("pop_last", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b1010, 0, 0);
        step("udf2", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b1010, 0, 1);
        step("pp_err_hold", 1, 0, 2'b00, 4'b0000, 1, 1, 0, 4'b1010, 0, 1);
        step("pushD", 1, 1, 2'b10, 4'b0111, 1, 0, 0, 4'b0111, 1, 1);
        step("mid_reset", 0, 1, 2'b10, 4'b1111, 1, 0, 0, 4'b0000, 0, 0);
        chk_cond("rst_ne", 4'h1, 1'b1);
        chk_cond("rst_eq", 4'h0, 1'b0);
        chk_cond("rst_hi", 4'h8, 1'b0);
        chk_cond("rst_nv", 4'hF, 1'b0);
        step("after_rst_pop", 1, 0, 2'b00, 4'b0000, 0, 1, 0, 4'b0000, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
